digit_entry_sequencer: RTL

//   Sequences keypad digit entry into the 4-bit universal shift register bank.

---
 rtl/digit_entry_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/digit_entry_sequencer.sv
// Keypad digit-entry controller: detects key presses, strobes the next free slot of
// the shift-register bank, issues clears and tracks count/full. Optional auto-clear: INPUT_TIMEOUT_EN.
module digit_entry_sequencer #(
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int CW            = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           key_code,
  input  logic                 clr_req,
  output logic [1:0]           reg_mode,
  output logic [NUM_SLOTS-1:0] wr_en,
  output logic [3:0]           wr_data,
  output logic                 clear_out,
  output logic [CW-1:0]        digit_count,
  output logic                 full,
  output logic                 overflow,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_RELEASE, CLEAR} state_t;

  localparam logic [NUM_SLOTS-1:0] SLOT0 = NUM_SLOTS'(1);

  state_t               state_q, state_d;
  logic                 key_d_q, press_q, clr_q;
  logic [3:0]           digit_q;
  logic [3:0]           wr_data_q, wr_data_d;
  logic [NUM_SLOTS-1:0] wr_en_q, wr_en_d;
  logic [1:0]           reg_mode_q, reg_mode_d;
  logic                 clear_q, clear_d;
  logic [CW-1:0]        count_q, count_d, count_inc;
  logic                 full_q, full_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic                 press;
  logic                 timeout;

  // The FSM acts on inputs sampled one edge earlier, so the slot strobe lands on
  // the second edge after the press and every output stays a plain register.
  assign press     = key_code[4] & ~key_d_q;
  assign count_inc = count_q + 1'b1;

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          idle_wait;

  assign idle_wait = (state_q == IDLE) || (state_q == WAIT_RELEASE);
  assign timeout   = idle_wait && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_d = '0;
    if (idle_wait && (count_q != '0) && !press_q && !timeout) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    full_d     = full_q;
    overflow_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_q || timeout) begin
          state_d = CLEAR;
        end else if (press_q) begin
          if (!full_q) begin
            state_d   = LOAD;
            wr_data_d = digit_q;
          end else begin
            state_d    = WAIT_RELEASE;
            overflow_d = 1'b1;
          end
        end
      end
      LOAD: begin
        count_d = count_inc;
        full_d  = (count_inc == CW'(NUM_SLOTS));
        done_d  = full_d;
        // A clear arriving mid-load is honoured once the slot write completes.
        state_d = clr_q ? CLEAR : WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (clr_q || timeout) state_d = CLEAR;
        else if (!key_d_q)    state_d = IDLE;
      end
      CLEAR: begin
        count_d = '0;
        full_d  = 1'b0;
        state_d = key_d_q ? WAIT_RELEASE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_en_d    = (state_d == LOAD) ? (SLOT0 << count_q) : '0;
    reg_mode_d = (state_d == LOAD) ? 2'b11 : 2'b00;
    clear_d    = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_d_q    <= 1'b0;
      press_q    <= 1'b0;
      clr_q      <= 1'b0;
      digit_q    <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= '0;
      reg_mode_q <= 2'b00;
      clear_q    <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_d_q    <= key_code[4];
      press_q    <= press;
      clr_q      <= clr_req;
      digit_q    <= key_code[3:0];
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      reg_mode_q <= reg_mode_d;
      clear_q    <= clear_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign reg_mode    = reg_mode_q;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign clear_out   = clear_q;
  assign digit_count = count_q;
  assign full        = full_q;
  assign overflow    = overflow_q;
  assign done        = done_q;

endmodule
